// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Two-master arbiter for the shared data-memory/UART port. Master 0 is the
//   multicycle CPU datapath and master 1 is the UART loader/debug engine.
//   Only one command is outstanding at a time. Read data is captured
//   RD_LAT cycles after the issue cycle and returned with a one-cycle
//   rvalid pulse. Ties are broken round-robin. A locking master may keep
//   the grant for up to MAX_LOCK extra accesses while the other master
//   is waiting.
//
// Ports
//   clk, rst_in        : rising-edge clock, asynchronous active-low reset
//   mN_req/we/lock     : request, write/read select, keep-grant hint
//   mN_addr/wdata      : command address and write data (held until gnt)
//   mN_gnt             : one-cycle pulse when the command is issued to the port
//   mN_rvalid/rdata    : one-cycle read-return pulse, registered read data
//   s_addr/s_din/s_we  : port command (address and data hold between accesses)
//   s_dout             : port read data
//   busy               : high whenever the arbiter is not idle
module dm_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 4
) (
   input  logic          clk,
   input  logic          rst_in,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_din,
   output logic          s_we,
   input  logic [DW-1:0] s_dout,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT);
   localparam logic [3:0] LOCK_LIM  = 4'(MAX_LOCK);

   state_t          state, state_nxt;
   logic            owner;
   logic            last_owner;
   logic            cmd_we;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic            lock_req;
   logic [3:0]      lock_cnt, lock_cnt_nxt;
   logic [1:0]      wait_cnt, wait_nxt;
   logic            win;
   logic            latch;
   logic            sample;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      latch        = 1'b0;
      sample       = 1'b0;
      win          = ~last_owner;
      lock_cnt_nxt = lock_cnt;
      wait_nxt     = wait_cnt;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               latch     = 1'b1;
               state_nxt = ISSUE;
               if (m0_req && !m1_req) begin
                  win          = 1'b0;
                  lock_cnt_nxt = 4'd0;
               end else if (!m0_req) begin
                  win          = 1'b1;
                  lock_cnt_nxt = 4'd0;
               end else if (lock_req && (lock_cnt < LOCK_LIM)) begin
                  // Both requesting, so the previous owner is requesting too:
                  // honour its lock while the extension budget lasts.
                  win          = last_owner;
                  lock_cnt_nxt = lock_cnt + 4'd1;
               end else begin
                  win          = ~last_owner;
                  lock_cnt_nxt = 4'd0;
               end
            end
         end
         ISSUE: begin
            if (cmd_we) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT;
               wait_nxt  = WAIT_INIT;
            end
         end
         WAIT: begin
            wait_nxt = wait_cnt - 2'd1;
            // Count of 1 marks the cycle RD_LAT after issue, when s_dout is valid.
            if (wait_cnt == 2'd1) begin
               sample    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         owner      <= 1'b0;
         last_owner <= 1'b1;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         lock_req   <= 1'b0;
         lock_cnt   <= 4'd0;
         wait_cnt   <= 2'd0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         wait_cnt <= wait_nxt;
         if (latch) begin
            owner      <= win;
            last_owner <= win;
            cmd_we     <= win ? m1_we    : m0_we;
            cmd_addr   <= win ? m1_addr  : m0_addr;
            cmd_wdata  <= win ? m1_wdata : m0_wdata;
            lock_req   <= win ? m1_lock  : m0_lock;
            lock_cnt   <= lock_cnt_nxt;
         end
         if (sample) begin
            if (owner) m1_rdata <= s_dout;
            else       m0_rdata <= s_dout;
         end
      end
   end

   // The command register drives the port directly, so address and data
   // stay on the port between accesses.
   assign s_addr    = cmd_addr;
   assign s_din     = cmd_wdata;
   assign s_we      = (state == ISSUE) && cmd_we;
   assign m0_gnt    = (state == ISSUE) && !owner;
   assign m1_gnt    = (state == ISSUE) &&  owner;
   assign m0_rvalid = (state == RESP)  && !owner;
   assign m1_rvalid = (state == RESP)  &&  owner;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Directed bench for dm_port_arbiter. Instance dut uses RD_LAT=1, instance
//   dut3 uses RD_LAT=3; both use MAX_LOCK=4 and share clock and reset.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_in;

   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] s_addr, s_din, s_dout;
   logic        s_we, busy;

   logic        c_m0_req, c_m0_we, c_m0_lock, c_m1_req, c_m1_we, c_m1_lock;
   logic [31:0] c_m0_addr, c_m0_wdata, c_m1_addr, c_m1_wdata;
   logic        c_m0_gnt, c_m0_rvalid, c_m1_gnt, c_m1_rvalid;
   logic [31:0] c_m0_rdata, c_m1_rdata;
   logic [31:0] c_s_addr, c_s_din, c_s_dout;
   logic        c_s_we, c_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_LOCK(4)) dut (
      .clk(clk), .rst_in(rst_in),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_din(s_din), .s_we(s_we), .s_dout(s_dout), .busy(busy)
   );

   dm_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_LOCK(4)) dut3 (
      .clk(clk), .rst_in(rst_in),
      .m0_req(c_m0_req), .m0_we(c_m0_we), .m0_lock(c_m0_lock), .m0_addr(c_m0_addr),
      .m0_wdata(c_m0_wdata), .m0_gnt(c_m0_gnt), .m0_rvalid(c_m0_rvalid), .m0_rdata(c_m0_rdata),
      .m1_req(c_m1_req), .m1_we(c_m1_we), .m1_lock(c_m1_lock), .m1_addr(c_m1_addr),
      .m1_wdata(c_m1_wdata), .m1_gnt(c_m1_gnt), .m1_rvalid(c_m1_rvalid), .m1_rdata(c_m1_rdata),
      .s_addr(c_s_addr), .s_din(c_s_din), .s_we(c_s_we), .s_dout(c_s_dout), .busy(c_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until one grant pulse is seen; -1 on timeout, 2 if both pulse.
   task automatic next_gnt(output int who);
      who = -1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (m0_gnt && m1_gnt) begin who = 2; return; end
         else if (m0_gnt)      begin who = 0; return; end
         else if (m1_gnt)      begin who = 1; return; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      int n;
      int lock_seq [7] = '{0, 1, 1, 1, 1, 1, 0};
      int alt_seq  [4] = '{1, 0, 1, 0};

      rst_in = 1'b0;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
      c_m0_req = 0; c_m0_we = 0; c_m0_lock = 0; c_m0_addr = 0; c_m0_wdata = 0;
      c_m1_req = 0; c_m1_we = 0; c_m1_lock = 0; c_m1_addr = 0; c_m1_wdata = 0;
      s_dout = 32'hDEADBEEF;
      c_s_dout = 32'h0;

      // Reset state
      repeat (2) tick();
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_gnt",   {30'd0, m0_gnt, m1_gnt}, 32'd0);
      chk("rst_rvld",  {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      chk("rst_swe",   {31'd0, s_we}, 32'd0);
      chk("rst_saddr", s_addr, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      rst_in = 1'b1;
      tick();

      // m0 read, RD_LAT=1: gnt in cycle 1, rvalid in cycle 3
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      chk("rd_c0_gnt", {31'd0, m0_gnt}, 32'd0);
      tick();
      m0_req = 0;
      chk("rd_c1_gnt",   {31'd0, m0_gnt}, 32'd1);
      chk("rd_c1_swe",   {31'd0, s_we}, 32'd0);
      chk("rd_c1_saddr", s_addr, 32'h10);
      chk("rd_c1_busy",  {31'd0, busy}, 32'd1);
      tick();
      chk("rd_c2_rvld", {31'd0, m0_rvalid}, 32'd0);
      tick();
      chk("rd_c3_rvld",  {31'd0, m0_rvalid}, 32'd1);
      chk("rd_c3_rdata", m0_rdata, 32'hDEADBEEF);
      chk("rd_c3_m1",    {m1_rdata[29:0], m1_rvalid, m1_gnt}, 32'd0);
      tick();
      chk("rd_c4_busy", {31'd0, busy}, 32'd0);

      // Simultaneous writes after a fresh reset: m0 first, then m1
      rst_in = 1'b0; tick(); rst_in = 1'b1; tick();
      m0_we = 1; m0_addr = 32'h4; m0_wdata = 32'h11; m0_req = 1;
      m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'h22; m1_req = 1;
      next_gnt(who);
      chk("wr_first", who, 0);
      chk("wr0_swe",  {31'd0, s_we}, 32'd1);
      chk("wr0_addr", s_addr, 32'h4);
      chk("wr0_din",  s_din, 32'h11);
      m0_req = 0;
      tick();
      chk("wr_gap_swe", {31'd0, s_we}, 32'd0);
      next_gnt(who);
      chk("wr_second", who, 1);
      chk("wr1_swe",  {31'd0, s_we}, 32'd1);
      chk("wr1_addr", s_addr, 32'h8);
      chk("wr1_din",  s_din, 32'h22);
      m1_req = 0;
      tick();
      chk("wr_end_swe",  {31'd0, s_we}, 32'd0);
      chk("wr_hold_addr", s_addr, 32'h8);
      // m1 was last owner, so the next tie goes to m0
      m0_req = 1; m1_req = 1;
      next_gnt(who);
      chk("rr_a", who, 0);
      m0_req = 0;
      next_gnt(who);
      chk("rr_b", who, 1);
      m1_req = 0;

      // m1 locking with m0 requesting continuously
      m1_lock = 1;
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 7; i++) begin
         next_gnt(who);
         chk($sformatf("lock_g%0d", i), who, lock_seq[i]);
      end
      m0_req = 0; m1_req = 0; m1_lock = 0;
      tick();
      m0_req = 1; m1_req = 1;
      for (int i = 0; i < 4; i++) begin
         next_gnt(who);
         chk($sformatf("alt_g%0d", i), who, alt_seq[i]);
      end
      m0_req = 0; m1_req = 0;
      repeat (2) tick();

      // RD_LAT=3 instance, m1 read; port data tagged with the cycle number
      for (int k = 0; k < 7; k++) begin
         c_s_dout = 32'hA0 + k;
         if (k == 0) begin c_m1_req = 1; c_m1_we = 0; c_m1_addr = 32'h100; end
         if (k == 1) c_m1_req = 0;
         chk($sformatf("l3_busy_c%0d", k), {31'd0, c_busy}, {31'd0, (k >= 1 && k <= 5)});
         chk($sformatf("l3_gnt_c%0d", k),  {31'd0, c_m1_gnt}, {31'd0, (k == 1)});
         chk($sformatf("l3_rvld_c%0d", k), {31'd0, c_m1_rvalid}, {31'd0, (k == 5)});
         if (k == 5) begin
            chk("l3_rdata", c_m1_rdata, 32'hA4);
            chk("l3_m0", {c_m0_rdata[29:0], c_m0_rvalid, c_m0_gnt}, 32'd0);
         end
         tick();
      end

      // m0 withdraws request right after its write is latched
      m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h55; m0_req = 1;
      tick();
      m0_req = 0;
      chk("wd_gnt",  {31'd0, m0_gnt}, 32'd1);
      chk("wd_swe",  {31'd0, s_we}, 32'd1);
      chk("wd_addr", s_addr, 32'h20);
      n = 0;
      repeat (6) begin
         tick();
         if (s_we || m0_gnt) n++;
      end
      chk("wd_no_second", n, 0);

      // Reset during WAIT of a read
      s_dout = 32'hCAFEF00D;
      m0_we = 0; m0_addr = 32'h30; m0_req = 1;
      tick();
      m0_req = 0;
      chk("ra_gnt", {31'd0, m0_gnt}, 32'd1);
      tick();
      chk("ra_busy_wait", {31'd0, busy}, 32'd1);
      rst_in = 1'b0;
      #1;
      chk("ra_busy",  {31'd0, busy}, 32'd0);
      chk("ra_ctrl",  {28'd0, m0_gnt, m1_gnt, m0_rvalid, s_we}, 32'd0);
      chk("ra_rdata", m0_rdata, 32'd0);
      chk("ra_saddr", s_addr, 32'd0);
      chk("ra_sdin",  s_din, 32'd0);
      tick();
      rst_in = 1'b1;
      n = 0;
      repeat (5) begin
         tick();
         if (m0_rvalid || m1_rvalid) n++;
      end
      chk("ra_no_rvld", n, 0);
      chk("ra_rdata_kept", m0_rdata, 32'd0);
      m0_we = 0; m0_addr = 32'h40; m0_req = 1;
      m1_we = 0; m1_addr = 32'h44; m1_req = 1;
      next_gnt(who);
      chk("ra_tie", who, 0);
      m0_req = 0;
      tick();
      tick();
      chk("ra_m0_rvld",  {31'd0, m0_rvalid}, 32'd1);
      chk("ra_m0_rdata", m0_rdata, 32'hCAFEF00D);
      next_gnt(who);
      chk("ra_m1_next", who, 1);
      m1_req = 0;
      tick();
      tick();
      chk("ra_m1_rvld",  {31'd0, m1_rvalid}, 32'd1);
      chk("ra_m1_rdata", m1_rdata, 32'hCAFEF00D);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
